// File: rtl/exponent_accelerator_pkg.sv
// Shared definitions for the exponent accelerator memory master.
//   ADDR_W  : word address width of the attached 8192x32 RAM
//   DATA_W  : data width, also the exponent loop bound
//   BE_ALL  : byte enable used for every RAM access
//   state_e : controller states
package exponent_accelerator_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    RD_BASE,
    RD_EXP,
    CAP_EXP,
    COMPUTE,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/exponent_accelerator_sqmul_step.sv
// One right-to-left square-and-multiply iteration (purely combinational).
//   acc, base, exp                : current loop state
//   acc_next, base_next, exp_next : loop state after this iteration
// Products keep only the low DATA_W bits (arithmetic mod 2^DATA_W).
module exponent_accelerator_sqmul_step
  import exponent_accelerator_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] exp,
  output logic [DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0] base_next,
  output logic [DATA_W-1:0] exp_next
);

  always_comb begin
    acc_next  = exp[0] ? acc * base : acc;
    base_next = base * base;
    exp_next  = exp >> 1;
  end

endmodule

// File: rtl/exponent_accelerator_mem_master.sv
// Avalon-MM master computing RAM[dst] = RAM[src] ** RAM[src+1] mod 2^DATA_W.
//   clk, reset      : clock, asynchronous active-high reset
//   start           : one-cycle job request, sampled only while idle
//   src_addr        : base word address (exponent at src_addr+1, wrapping)
//   dst_addr        : result word address
//   busy            : high in every state except IDLE
//   done            : one-cycle pulse after the result write
//   result          : last computed value, updated in the WRITE cycle
//   mem_*           : RAM master interface (1-cycle read latency, no waitrequest)
// All RAM strobes and status outputs are registered; their next values are
// derived from the next state so they line up with the state they belong to.
module exponent_accelerator_mem_master
  import exponent_accelerator_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_d;

  logic              busy_d, done_d, cs_d, we_d;
  logic [ADDR_W-1:0] address_d;
  logic [DATA_W-1:0] writedata_d;

  logic [DATA_W-1:0] step_acc, step_base, step_exp;

  assign mem_byteenable = BE_ALL;
  assign mem_clken      = 1'b1;

  exponent_accelerator_sqmul_step u_step (
    .acc       (acc_q),
    .base      (base_q),
    .exp       (exp_q),
    .acc_next  (step_acc),
    .base_next (step_base),
    .exp_next  (step_exp)
  );

  // State and register process.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      base_q         <= '0;
      exp_q          <= '0;
      acc_q          <= '0;
      result         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      base_q         <= base_d;
      exp_q          <= exp_d;
      acc_q          <= acc_d;
      result         <= result_d;
      busy           <= busy_d;
      done           <= done_d;
      mem_address    <= address_d;
      mem_chipselect <= cs_d;
      mem_write      <= we_d;
      mem_writedata  <= writedata_d;
    end
  end

  // Next-state process.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RD_BASE;
      RD_BASE: state_d = RD_EXP;
      RD_EXP:  state_d = CAP_EXP;
      CAP_EXP: state_d = (mem_readdata == '0) ? WRITE : COMPUTE;
      // Leave as soon as the shifted exponent runs out of set bits.
      COMPUTE: if (step_exp == '0) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    base_d   = base_q;
    exp_d    = exp_q;
    acc_d    = acc_q;
    result_d = result;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
        end
      end
      RD_EXP:  base_d = mem_readdata;
      CAP_EXP: begin
        exp_d = mem_readdata;
        acc_d = DATA_W'(1);
      end
      COMPUTE: begin
        acc_d  = step_acc;
        base_d = step_base;
        exp_d  = step_exp;
      end
      WRITE:   result_d = acc_q;
      default: ;
    endcase

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    address_d   = mem_address;
    writedata_d = mem_writedata;
    cs_d        = 1'b0;
    we_d        = 1'b0;

    unique case (state_d)
      RD_BASE: begin
        address_d = src_d;
        cs_d      = 1'b1;
      end
      RD_EXP: begin
        address_d = src_q + ADDR_W'(1);
        cs_d      = 1'b1;
      end
      WRITE: begin
        // acc_d is the final accumulator, whether entered from CAP_EXP or COMPUTE.
        address_d   = dst_q;
        writedata_d = acc_d;
        cs_d        = 1'b1;
        we_d        = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exponent_accelerator_mem_master.sv
module tb_exponent_accelerator_mem_master;
  import exponent_accelerator_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] src_addr = '0;
  logic [ADDR_W-1:0] dst_addr = '0;
  logic              busy, done;
  logic [DATA_W-1:0] result;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata = '0;

  exponent_accelerator_mem_master dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model with a bench-side preload port.
  logic [DATA_W-1:0] ram [0:8191];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [DATA_W-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (mem_chipselect && mem_write) ram[mem_address] <= mem_writedata;
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: left-to-right binary exponentiation on 64-bit integers.
  function automatic logic [31:0] model_pow(input logic [31:0] b, input logic [31:0] e);
    longint unsigned r = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) & 64'hFFFF_FFFF;
      if (e[i]) r = (r * longint'(b)) & 64'hFFFF_FFFF;
    end
    return r[31:0];
  endfunction

  function automatic int bit_len(input logic [31:0] e);
    int n = 0;
    for (int i = 0; i < 32; i++) if (e[i]) n = i + 1;
    return n;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] dst;
    logic [31:0]       val;
    int                t0;
    int                n;
  } job_t;

  job_t sb[$];

  // Monitor: checks writes, busy window and each done pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_write) begin
        if (sb.size() == 0) begin
          check_eq("write with no job", {31'b0, mem_write}, 32'd0);
        end else begin
          check_eq("write chipselect", {31'b0, mem_chipselect}, 32'd1);
          check_eq("write address", {19'b0, mem_address}, {19'b0, sb[0].dst});
          check_eq("write data", mem_writedata, sb[0].val);
        end
      end
      if (sb.size() != 0 && (cyc - sb[0].t0) >= 1 && (cyc - sb[0].t0) <= 5 + sb[0].n)
        check_eq("busy in job", {31'b0, busy}, 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          check_eq("done with no job", {31'b0, done}, 32'd0);
        end else begin
          check_eq("done latency", cyc - sb[0].t0, 5 + sb[0].n);
          check_eq("result", result, sb[0].val);
          check_eq("ram dst", ram[sb[0].dst], sb[0].val);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Loads operands and issues start; returns #1 into cycle 1 of the job.
  task automatic run_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                         input logic [31:0] b, input logic [31:0] e);
    logic [ADDR_W-1:0] src1;
    job_t j;
    src1 = src + 13'd1;
    preload(src, b);
    preload(src1, e);
    j.dst = dst;
    j.val = model_pow(b, e);
    j.t0  = cyc;
    j.n   = bit_len(e);
    sb.push_back(j);
    start    = 1'b1;
    src_addr = src;
    dst_addr = dst;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check_eq("job timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b, e;
    logic [ADDR_W-1:0] s, d;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst done", {31'b0, done}, 32'd0);
    check_eq("rst result", result, 32'd0);
    check_eq("rst address", {19'b0, mem_address}, 32'd0);
    check_eq("rst cs", {31'b0, mem_chipselect}, 32'd0);
    check_eq("rst we", {31'b0, mem_write}, 32'd0);
    check_eq("rst wdata", mem_writedata, 32'd0);
    check_eq("byteenable", {28'b0, mem_byteenable}, 32'h0000000F);
    check_eq("clken", {31'b0, mem_clken}, 32'd1);

    // Directed jobs.
    run_job(13'h010, 13'h020, 32'd3, 32'd5);                  wait_idle();
    check_eq("t1 value", ram[13'h020], 32'd243);
    run_job(13'h100, 13'h102, 32'd7, 32'd0);                  wait_idle();
    run_job(13'h110, 13'h120, 32'hFFFF_FFFF, 32'd2);          wait_idle();
    run_job(13'h130, 13'h140, 32'd2, 32'hFFFF_FFFF);          wait_idle();
    run_job(13'h1FFF, 13'h0005, 32'd2, 32'd10);               wait_idle();
    check_eq("wrap value", ram[13'h0005], 32'd1024);
    run_job(13'h150, 13'h151, 32'd9, 32'd7);                  wait_idle();

    // Reset during COMPUTE abandons the job.
    preload(13'h300, 32'hDEAD_BEEF);
    run_job(13'h200, 13'h300, 32'd3, 32'h0000_FFFF);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    sb.delete();
    check_eq("mid rst busy", {31'b0, busy}, 32'd0);
    check_eq("mid rst cs", {31'b0, mem_chipselect}, 32'd0);
    check_eq("mid rst we", {31'b0, mem_write}, 32'd0);
    check_eq("mid rst result", result, 32'd0);
    check_eq("mid rst address", {19'b0, mem_address}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("abandoned dst", ram[13'h300], 32'hDEAD_BEEF);
    run_job(13'h210, 13'h310, 32'd5, 32'd3);                  wait_idle();

    // Start while busy is ignored.
    preload(13'h400, 32'h1234_5678);
    run_job(13'h040, 13'h050, 32'd5, 32'h13);
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    src_addr = 13'h060;
    dst_addr = 13'h400;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    check_eq("ignored dst", ram[13'h400], 32'h1234_5678);

    // Randomised jobs.
    for (int i = 0; i < 24; i++) begin
      s = 13'($urandom_range(0, 8191));
      d = 13'($urandom_range(0, 8191));
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      case ($urandom_range(0, 3))
        0:       e = 32'd0;
        1:       e = 32'($urandom_range(1, 40));
        2:       e = $urandom;
        default: e = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      endcase
      run_job(s, d, b, e);
      wait_idle();
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
